// File: rtl/qch_pkg.sv
// Shared types and constants for the device-side Q-Channel responder.
// Holds the FSM state encoding, the registered-output bundle with its
// per-state decode, and the default flush timeout.
package qch_pkg;

  localparam int unsigned FLUSH_TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    Q_RUN      = 3'd0,
    Q_REQUEST  = 3'd1,
    Q_STOPPED  = 3'd2,
    Q_EXIT     = 3'd3,
    Q_DENIED   = 3'd4,
    Q_CONTINUE = 3'd5
  } qch_state_t;

  // Registered handshake / gating outputs driven from the FSM state.
  typedef struct packed {
    logic qacceptn;
    logic qdeny;
    logic wr_flush;
    logic icg_en;
  } qch_out_t;

  localparam qch_out_t QCH_OUT_RST = '{qacceptn: 1'b1, qdeny: 1'b0,
                                       wr_flush: 1'b0, icg_en: 1'b1};

  // Output values associated with each state; accept and deny are never both active.
  function automatic qch_out_t qch_decode(input qch_state_t s);
    qch_out_t o;
    o = QCH_OUT_RST;
    case (s)
      Q_REQUEST: o.wr_flush = 1'b1;
      Q_STOPPED: begin
        o.qacceptn = 1'b0;
        o.icg_en   = 1'b0;
      end
      Q_EXIT:    o.qacceptn = 1'b0;
      Q_DENIED:  o.qdeny    = 1'b1;
      default:   o = QCH_OUT_RST;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/qch_sync.sv
// Multi-flop synchroniser for a single asynchronous control bit.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, loads RST_VAL into every stage
//   i_d  - asynchronous input
//   o_q  - synchronised output, STAGES cycles behind i_d
module qch_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift chain; the last stage is the only one consumed downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/qch_device_responder.sv
// Device-side Q-Channel responder on the ungated device clock.
// Synchronises qreqn_i / if_wakeup_i, sequences a write-FIFO flush, then
// accepts (and gates the device clock) or denies the quiescence request.
// Ports:
//   clk_a, reset         - free-running device clock, async active-high reset
//   qreqn_i              - async Q-Channel request (active-low)
//   qacceptn_o, qdeny_o  - Q-Channel accept (active-low) / deny
//   qactive_o            - device busy or wakeup pending
//   if_wakeup_i          - async wakeup request
//   wr_valid_i           - write presented to the device FIFO this cycle
//   fifo_empty_i         - device write FIFO empty
//   wr_flush_o, wr_done_i- flush request / completion handshake
//   device_icg_enable    - device clock-gate enable (1 = clock runs)
module qch_device_responder
  import qch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W         = 5
) (
  input  logic clk_a,
  input  logic reset,
  input  logic qreqn_i,
  output logic qacceptn_o,
  output logic qdeny_o,
  output logic qactive_o,
  input  logic if_wakeup_i,
  input  logic wr_valid_i,
  input  logic fifo_empty_i,
  output logic wr_flush_o,
  input  logic wr_done_i,
  output logic device_icg_enable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             w_qreqn_s;
  logic             w_wake_s;
  qch_state_t       r_state;
  qch_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  qch_out_t         r_out;
  qch_out_t         w_out_nxt;
  logic             r_qactive;
  logic             w_qactive_nxt;

  // Request idles high (no request), wakeup idles low.
  qch_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_qreqn (
    .clk (clk_a),
    .rst (reset),
    .i_d (qreqn_i),
    .o_q (w_qreqn_s)
  );

  qch_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_wake (
    .clk (clk_a),
    .rst (reset),
    .i_d (if_wakeup_i),
    .o_q (w_wake_s)
  );

  // State, counter and output registers.
  always_ff @(posedge clk_a or posedge reset) begin
    if (reset) begin
      r_state   <= Q_RUN;
      r_cnt     <= '0;
      r_out     <= QCH_OUT_RST;
      r_qactive <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_out     <= w_out_nxt;
      r_qactive <= w_qactive_nxt;
    end
  end

  // Next state; outputs follow the current state, so they lag a transition by one cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_out_nxt     = qch_decode(r_state);
    w_qactive_nxt = ~fifo_empty_i | wr_valid_i | w_wake_s;

    case (r_state)
      Q_RUN: begin
        if (!w_qreqn_s) begin
          w_state_nxt = Q_REQUEST;
          w_cnt_nxt   = '0;
        end
      end
      Q_REQUEST: begin
        if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        // New work beats completion; completion beats timeout.
        if (wr_valid_i || w_wake_s) begin
          w_state_nxt = Q_DENIED;
        end else if (wr_done_i && fifo_empty_i) begin
          w_state_nxt = Q_STOPPED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = Q_DENIED;
        end else if (w_qreqn_s) begin
          // Controller withdrew the request before a response: drop back.
          w_state_nxt = Q_RUN;
        end
      end
      Q_STOPPED: begin
        // Wakeup only shows on qactive_o; leaving needs the controller.
        if (w_qreqn_s) begin
          w_state_nxt = Q_EXIT;
        end
      end
      Q_EXIT: begin
        // One cycle with the clock ungated before acceptance is released.
        w_state_nxt = Q_RUN;
      end
      Q_DENIED: begin
        if (w_qreqn_s) begin
          w_state_nxt = Q_CONTINUE;
        end
      end
      Q_CONTINUE: begin
        w_state_nxt = Q_RUN;
      end
      default: begin
        w_state_nxt = Q_RUN;
      end
    endcase
  end

  assign qacceptn_o        = r_out.qacceptn;
  assign qdeny_o           = r_out.qdeny;
  assign wr_flush_o        = r_out.wr_flush;
  assign device_icg_enable = r_out.icg_en;
  assign qactive_o         = r_qactive;

endmodule

// File: tb/tb_qch_device_responder.sv
// Directed bench for qch_device_responder: a cycle-by-cycle vector table for
// the accept and deny handshakes, plus hand-written multi-cycle sequences.
// Output vectors are packed as {qacceptn, qdeny, qactive, wr_flush, icg_en}.
module tb_qch_device_responder;

  logic clk_a = 1'b0;
  logic reset;
  logic qreqn_i;
  logic if_wakeup_i;
  logic wr_valid_i;
  logic fifo_empty_i;
  logic wr_done_i;
  logic qacceptn_o;
  logic qdeny_o;
  logic qactive_o;
  logic wr_flush_o;
  logic device_icg_enable;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_a = ~clk_a;

  qch_device_responder #(
    .SYNC_STAGES   (2),
    .FLUSH_TIMEOUT (16),
    .CNT_W         (5)
  ) dut (
    .clk_a             (clk_a),
    .reset             (reset),
    .qreqn_i           (qreqn_i),
    .qacceptn_o        (qacceptn_o),
    .qdeny_o           (qdeny_o),
    .qactive_o         (qactive_o),
    .if_wakeup_i       (if_wakeup_i),
    .wr_valid_i        (wr_valid_i),
    .fifo_empty_i      (fifo_empty_i),
    .wr_flush_o        (wr_flush_o),
    .wr_done_i         (wr_done_i),
    .device_icg_enable (device_icg_enable)
  );

  typedef struct {
    logic       q;
    logic       wk;
    logic       v;
    logic       e;
    logic       d;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [4:0] O_RUN   = 5'b10001;
  localparam logic [4:0] O_STOP  = 5'b00000;
  localparam logic [4:0] O_EXIT  = 5'b00001;
  localparam logic [4:0] O_DENY  = 5'b11001;

  function automatic logic [4:0] outs();
    return {qacceptn_o, qdeny_o, qactive_o, wr_flush_o, device_icg_enable};
  endfunction

  task automatic tick();
    @(negedge clk_a);
  endtask

  task automatic drive(input logic q, input logic wk, input logic v,
                       input logic e, input logic d);
    qreqn_i      = q;
    if_wakeup_i  = wk;
    wr_valid_i   = v;
    fifo_empty_i = e;
    wr_done_i    = d;
  endtask

  task automatic add(input int n, input logic q, input logic wk, input logic v,
                     input logic e, input logic d, input logic [4:0] exp);
    for (int i = 0; i < n; i++) vecs.push_back(vec_t'{q, wk, v, e, d, exp});
  endtask

  task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ticks until wr_flush_o is seen high, bounded.
  task automatic wait_flush(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (wr_flush_o) seen = 1'b1;
    end
    chk_int(name, int'(seen), 1);
  endtask

  // Ticks until qdeny_o is seen low, bounded.
  task automatic wait_deny_low(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (!qdeny_o) seen = 1'b1;
    end
    chk_int(name, int'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;

    // Reset held 10 cycles, then released.
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) tick();
    chk5("reset_hold", outs(), O_RUN);
    reset = 1'b0;
    tick();
    chk5("reset_release", outs(), O_RUN);

    // Accept path: 5 writes, request, flush done 4 cycles after flush rises, exit.
    add(5, 1, 0, 1, 0, 0, 5'b10101);
    add(3, 0, 0, 0, 0, 0, 5'b10101);
    add(2, 0, 0, 0, 0, 0, 5'b10111);
    add(2, 0, 0, 0, 1, 0, 5'b10011);
    add(1, 0, 0, 0, 1, 1, 5'b10011);
    add(3, 0, 0, 0, 1, 0, O_STOP);
    add(3, 1, 0, 0, 1, 0, O_STOP);
    add(1, 1, 0, 0, 1, 0, O_EXIT);
    add(1, 1, 0, 0, 1, 0, O_RUN);
    // Deny path: done in Q_RUN ignored, write during flush, release.
    add(2, 0, 0, 0, 1, 1, O_RUN);
    add(1, 0, 0, 0, 1, 0, O_RUN);
    add(1, 0, 0, 0, 1, 0, 5'b10011);
    add(1, 0, 0, 1, 1, 0, 5'b10111);
    add(2, 0, 0, 0, 1, 0, O_DENY);
    add(3, 1, 0, 0, 1, 0, O_DENY);
    add(2, 1, 0, 0, 1, 0, O_RUN);

    foreach (vecs[i]) begin
      drive(vecs[i].q, vecs[i].wk, vecs[i].v, vecs[i].e, vecs[i].d);
      tick();
      chk5($sformatf("vec%0d", i + 1), outs(), vecs[i].exp);
    end

    // Timeout, with done asserted while the FIFO is still non-empty.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_flush("t4_flush_rise");
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      n++;
      if (qdeny_o) seen = 1'b1;
    end
    chk_int("t4_timeout_cycles", n, 16);
    chk5("t4_denied", outs(), 5'b11101);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_deny_low("t4_deny_release");
    chk5("t4_continue", outs(), O_RUN);
    tick();
    chk5("t4_run", outs(), O_RUN);

    // Done arriving in the same cycle as the timeout: done wins.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_flush("tt_flush_rise");
    repeat (14) tick();
    chk5("tt_still_request", outs(), 5'b10011);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk5("tt_done_beats_timeout", outs(), O_STOP);

    // Wakeup while stopped only raises qactive_o.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) if_wakeup_i = 1'b0;
      tick();
      if (qactive_o) seen = 1'b1;
      chk5($sformatf("t5_hold%0d", i), {qacceptn_o, qdeny_o, 1'b0, wr_flush_o, device_icg_enable}, O_STOP);
    end
    chk_int("t5_wake_active", int'(seen), 1);
    repeat (4) tick();
    chk5("t5_still_stopped", outs(), O_STOP);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk5("t5_pre_exit", outs(), O_STOP);
    tick();
    chk5("t5_exit", outs(), O_EXIT);
    tick();
    chk5("t5_run", outs(), O_RUN);

    // Write and done in the same cycle: deny wins.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_flush("dd_flush_rise");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk5("dd_deny_beats_done", outs(), O_DENY);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_deny_low("dd_deny_release");
    tick();
    chk5("dd_run", outs(), O_RUN);

    // Asynchronous reset while stopped.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_flush("t6_flush_rise");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk5("t6_stopped", outs(), O_STOP);
    #2;
    reset = 1'b1;
    #1;
    chk5("t6_async_reset", outs(), O_RUN);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk5("t6_after_reset", outs(), O_RUN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qch_device_responder.md
Name: qch_device_responder

Overview:
Device-side Q-Channel responder. It is the counterpart to the controller that drives qreqn.
- Receives the asynchronous qreqn from the controller.
- Sequences a write-FIFO flush through the wr_flush_o / wr_done_i handshake.
- Accepts or denies the quiescence request and drives the device clock-gate enable.
- Sits in the device domain on the ungated clk_a, alongside the device write FIFO.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the qreqn_i and if_wakeup_i synchronisers (minimum 2).
- FLUSH_TIMEOUT, 16: cycles allowed in Q_REQUEST for the flush to complete before the request is denied.
- CNT_W, 5: width of the flush timeout counter; must satisfy 2^CNT_W > FLUSH_TIMEOUT.

Ports:
- clk_a, input, 1: device clock, free-running and never gated by this block.
- reset, input, 1: asynchronous, active-high reset.
- qreqn_i, input, 1: Q-Channel request from the controller, active-low, asynchronous.
- qacceptn_o, output, 1: Q-Channel accept, active-low.
- qdeny_o, output, 1: Q-Channel deny.
- qactive_o, output, 1: device has work pending or a wakeup is requested.
- if_wakeup_i, input, 1: asynchronous wakeup request from the environment.
- wr_valid_i, input, 1: a write is being presented to the device FIFO this cycle.
- fifo_empty_i, input, 1: device write FIFO is empty.
- wr_flush_o, output, 1: flush request to the FIFO read side.
- wr_done_i, input, 1: read side reports the flush is complete.
- device_icg_enable, output, 1: enable for the device clock gate; 1 means the device clock runs.

Behaviour:
- Clocking and reset: one clock, clk_a; reset is asynchronous and active-high. All outputs are registered.
- Reset values: qacceptn_o=1, qdeny_o=0, qactive_o=0, wr_flush_o=0, device_icg_enable=1, state=Q_RUN, counter=0.
- Synchronisation: qreqn_i and if_wakeup_i pass through SYNC_STAGES flops, giving qreqn_s and wake_s. Synchroniser reset values: qreqn_s=1, wake_s=0.
- Latency: an input edge affects the state machine SYNC_STAGES cycles later. Outputs change one cycle after the state transition.
- qactive_o is registered every cycle in every state as (~fifo_empty_i | wr_valid_i | wake_s).

State machine (encoded in the package):
- Q_RUN: qacceptn=1, qdeny=0. Go to Q_REQUEST when qreqn_s==0; the counter clears on entry.
- Q_REQUEST:
  - wr_flush_o=1 and the counter increments each cycle.
  - Priority 1: wr_valid_i or wake_s -> Q_DENIED, and wr_flush_o drops.
  - Priority 2: wr_done_i & fifo_empty_i -> Q_STOPPED.
  - Priority 3: counter == FLUSH_TIMEOUT-1 -> Q_DENIED.
  - Priority 4: qreqn_s==1 is a protocol violation -> Q_RUN, wr_flush_o=0, nothing accepted.
- Q_STOPPED: qacceptn_o=0, wr_flush_o=0, device_icg_enable=0. Go to Q_EXIT when qreqn_s==1.
- Q_EXIT: device_icg_enable=1 and qacceptn_o held at 0 for exactly one cycle so the gated clock restarts before acceptance is released. Then go to Q_RUN, where qacceptn_o=1.
- Q_DENIED: qdeny_o=1, qacceptn_o=1. Go to Q_CONTINUE when qreqn_s==1.
- Q_CONTINUE: qdeny_o=0, one cycle, then Q_RUN.

Boundary rules:
- wr_done_i=1 while fifo_empty_i=0: keep waiting; the timeout still applies.
- Deny and done in the same cycle: deny wins.
- Done and timeout in the same cycle: done wins, go to Q_STOPPED.
- wr_done_i outside Q_REQUEST is ignored.
- wake_s while in Q_STOPPED only raises qactive_o. The block waits for the controller to raise qreqn and never leaves Q_STOPPED on its own.
- Reset asserted in any state, including Q_STOPPED, returns all outputs to reset values immediately (asynchronously). device_icg_enable returns to 1.
- The counter saturates and never wraps.
- qacceptn_o and qdeny_o are never both active (qacceptn_o=0 and qdeny_o=1) in the same cycle.

Decomposition:
- Package qch_pkg holds:
  - typedef enum logic [2:0] qch_state_t: Q_RUN=0, Q_REQUEST=1, Q_STOPPED=2, Q_EXIT=3, Q_DENIED=4, Q_CONTINUE=5.
  - The default FLUSH_TIMEOUT constant.
- Sub-module qch_sync: a parameterised SYNC_STAGES synchroniser with a reset-value parameter. It is instantiated twice, once for qreqn_i and once for if_wakeup_i.

Test Plan:
1. Reset held 10 cycles, then released -> qacceptn_o=1, qdeny_o=0, device_icg_enable=1, wr_flush_o=0, state Q_RUN.
2. Write 5 words, drop qreqn_i, return wr_done_i=1 with fifo_empty_i=1 four cycles after wr_flush_o rises -> qacceptn_o=0 and device_icg_enable=0 one cycle later. Then raise qreqn_i -> device_icg_enable=1 two cycles after the synchronised edge, and qacceptn_o=1 one cycle after that.
3. Drop qreqn_i and pulse wr_valid_i during Q_REQUEST -> qdeny_o=1, wr_flush_o=0, qacceptn_o stays 1. Raise qreqn_i -> qdeny_o=0 and back to Q_RUN.
4. Drop qreqn_i and never assert wr_done_i, with FLUSH_TIMEOUT=16 -> qdeny_o=1 exactly 16 cycles after entering Q_REQUEST.
5. Pulse if_wakeup_i in Q_STOPPED -> qactive_o=1 within SYNC_STAGES+1 cycles while qacceptn_o stays 0. Controller raises qreqn_i -> Q_EXIT, then Q_RUN.
6. Assert reset in Q_STOPPED -> device_icg_enable=1, qacceptn_o=1 and qdeny_o=0 immediately (asynchronously), with no clock edge required.
